// File: rtl/imem_ctrl_pkg.sv
// Shared constants and response-owner encoding for the instruction-memory controller.
package imem_ctrl_pkg;

  localparam logic [31:0] NOP_INSTR            = 32'h00000013;
  localparam logic [3:0]  EXC_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0]  EXC_INSTR_ACCESS     = 4'd1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LD   = 2'd2
  } owner_e;

endpackage

// File: rtl/imem_addr_chk.sv
// Combinational byte-address check: word alignment, range against RAM depth, word index.
// Zero latency; no handshake.
module imem_addr_chk
  import imem_ctrl_pkg::*;
#(
  parameter int MEM_WORDS = 2048,
  parameter int IDX_W     = 11
) (
  input  logic [63:0]      i_addr,
  output logic             o_misaligned,
  output logic             o_out_of_range,
  output logic [IDX_W-1:0] o_idx
);

  assign o_misaligned   = |i_addr[1:0];
  // Full 62-bit compare so high address bits can never alias onto a low index.
  assign o_out_of_range = i_addr[63:2] >= 62'(MEM_WORDS);
  assign o_idx          = i_addr[IDX_W+1:2];

endmodule

// File: rtl/imem_ctrl.sv
// Round-robin fetch/loader arbiter in front of a single-port sync-read instruction RAM.
// One accept per cycle, response one cycle later; responses have no backpressure.
module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int MEM_WORDS = 2048,
  parameter int IDX_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req_valid,
  output logic             if_req_ready,
  input  logic [63:0]      if_req_addr,
  input  logic             if_flush,
  output logic             if_rsp_valid,
  output logic [31:0]      if_rsp_instr,
  output logic             if_rsp_exc_en,
  output logic [3:0]       if_rsp_exc_code,
  output logic [63:0]      if_rsp_exc_val,
  input  logic             ld_req_valid,
  output logic             ld_req_ready,
  input  logic             ld_req_we,
  input  logic [63:0]      ld_req_addr,
  input  logic [31:0]      ld_req_wdata,
  output logic             ld_rsp_valid,
  output logic [31:0]      ld_rsp_rdata,
  output logic             ld_rsp_err,
  output logic             mem_en,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_idx,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  logic             w_if_mis, w_if_oor, w_ld_mis, w_ld_oor;
  logic [IDX_W-1:0] w_if_idx, w_ld_idx;
  logic             w_acc_fault, w_acc_mis, w_if_vld, w_ld_vld;

  logic             r_last_ld;
  owner_e           r_rsp_owner;
  logic             r_rsp_fault;
  logic             r_rsp_rd;
  logic             r_rsp_flush;
  logic [3:0]       r_rsp_code;
  logic [63:0]      r_rsp_val;

  imem_addr_chk #(.MEM_WORDS(MEM_WORDS), .IDX_W(IDX_W)) u_if_chk (
    .i_addr(if_req_addr), .o_misaligned(w_if_mis), .o_out_of_range(w_if_oor), .o_idx(w_if_idx)
  );

  imem_addr_chk #(.MEM_WORDS(MEM_WORDS), .IDX_W(IDX_W)) u_ld_chk (
    .i_addr(ld_req_addr), .o_misaligned(w_ld_mis), .o_out_of_range(w_ld_oor), .o_idx(w_ld_idx)
  );

  // Grants are suppressed while reset is held so nothing reaches the RAM.
  assign if_req_ready = rst & if_req_valid & (~ld_req_valid | r_last_ld);
  assign ld_req_ready = rst & ld_req_valid & ~if_req_ready;

  assign w_acc_mis   = if_req_ready ? w_if_mis : w_ld_mis;
  assign w_acc_fault = if_req_ready ? (w_if_mis | w_if_oor) : (w_ld_mis | w_ld_oor);

  assign mem_en    = (if_req_ready | ld_req_ready) & ~w_acc_fault;
  assign mem_we    = ld_req_ready & ld_req_we & ~w_acc_fault;
  assign mem_idx   = if_req_ready ? w_if_idx : w_ld_idx;
  assign mem_wdata = ld_req_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_ld   <= 1'b1;
      r_rsp_owner <= OWN_NONE;
      r_rsp_fault <= 1'b0;
      r_rsp_rd    <= 1'b0;
      r_rsp_flush <= 1'b0;
      r_rsp_code  <= 4'd0;
      r_rsp_val   <= 64'd0;
    end else begin
      if (if_req_ready) begin
        r_last_ld <= 1'b0;
      end else if (ld_req_ready) begin
        r_last_ld <= 1'b1;
      end
      r_rsp_owner <= if_req_ready ? OWN_IF : (ld_req_ready ? OWN_LD : OWN_NONE);
      r_rsp_fault <= w_acc_fault;
      r_rsp_rd    <= ~ld_req_we;
      r_rsp_flush <= if_flush;
      r_rsp_code  <= w_acc_mis ? EXC_INSTR_MISALIGNED : EXC_INSTR_ACCESS;
      r_rsp_val   <= if_req_ready ? if_req_addr : ld_req_addr;
    end
  end

  // A flush seen at accept or at response time kills the fetch response.
  assign w_if_vld = (r_rsp_owner == OWN_IF) & ~r_rsp_flush & ~if_flush;
  assign w_ld_vld = (r_rsp_owner == OWN_LD);

  assign if_rsp_valid    = w_if_vld;
  assign if_rsp_instr    = (w_if_vld & ~r_rsp_fault) ? mem_rdata : NOP_INSTR;
  assign if_rsp_exc_en   = w_if_vld & r_rsp_fault;
  assign if_rsp_exc_code = if_rsp_exc_en ? r_rsp_code : 4'd0;
  assign if_rsp_exc_val  = if_rsp_exc_en ? r_rsp_val : 64'd0;

  assign ld_rsp_valid = w_ld_vld;
  assign ld_rsp_rdata = (w_ld_vld & ~r_rsp_fault & r_rsp_rd) ? mem_rdata : 32'd0;
  assign ld_rsp_err   = w_ld_vld & r_rsp_fault;

endmodule

// File: doc/imem_ctrl.md
# imem_ctrl

Instruction-memory access controller. It sits between the fetch stage, the program-loader/debug port and a single-port, synchronous-read instruction RAM. It arbitrates the two requesters round-robin and range/alignment-checks every fetch, returning a fault descriptor instead of touching the RAM. It issues at most one RAM access per cycle and returns each response exactly one cycle after acceptance.

## Interface

Parameters:
- MEM_WORDS, 2048: RAM depth in 32-bit words.
- IDX_W, 11: RAM index width, equal to clog2(MEM_WORDS).

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- if_req_valid / if_req_ready, in / out, 1: fetch request handshake.
- if_req_addr, input, 64: fetch PC.
- if_flush, input, 1: discards an in-flight fetch response.
- if_rsp_valid, output, 1: fetch response strobe.
- if_rsp_instr, output, 32: fetched word; 0x00000013 when faulted or not valid.
- if_rsp_exc_en, output, 1: fault flag.
- if_rsp_exc_code, output, 4: 0 = misaligned, 1 = access fault.
- if_rsp_exc_val, output, 64: faulting PC.
- ld_req_valid / ld_req_ready, in / out, 1: loader request handshake.
- ld_req_we, input, 1: 1 = write, 0 = read.
- ld_req_addr, input, 64: byte address.
- ld_req_wdata, input, 32: write data.
- ld_rsp_valid, output, 1: loader response strobe; issued for reads and writes.
- ld_rsp_rdata, output, 32: read data; 0 on writes or errors.
- ld_rsp_err, output, 1: address out of range or misaligned.
- mem_en / mem_we, output, 1: RAM enable and write enable.
- mem_idx, output, IDX_W: RAM word index, equal to addr[IDX_W+1:2].
- mem_wdata, output, 32: RAM write data.
- mem_rdata, input, 32: RAM read data, valid the cycle after mem_en.

## Operation

- **Address check** (both ports):
  - misaligned = addr[1:0] != 0
  - out_of_range = addr[63:2] >= MEM_WORDS, compared on the full 62-bit index with no truncation.
  - Misaligned takes precedence over out_of_range.
- **Arbitration**:
  - last_grant register; reset value LD, so fetch wins the first conflict.
  - Only one side is valid: that side is granted.
  - Both sides are valid: the side not equal to last_grant is granted.
  - last_grant updates on every accepted request.
  - if_req_ready and ld_req_ready are combinational grant signals. Ready is never asserted for a non-valid port.
- **Accepted request with a clean address**: mem_en = 1, mem_we = ld_req_we for loader writes, otherwise 0. mem_idx and mem_wdata are driven in the same cycle.
- **Accepted request with a faulting address**: mem_en = 0. The fault descriptor is registered for the response.
- **Response stage**: pipeline registers rsp_owner (NONE / IF / LD), rsp_fault, rsp_code, rsp_val.
  - Fetch: if_rsp_valid = 1.
    - No fault: if_rsp_instr = mem_rdata.
    - Fault: if_rsp_exc_en = 1, exc_code and exc_val per the address check, if_rsp_instr = 0x00000013.
  - Loader: ld_rsp_valid = 1. ld_rsp_rdata = mem_rdata for clean reads, otherwise 0. ld_rsp_err = fault.
- **Flush**: if_flush high during the acceptance cycle or the response cycle of a fetch forces if_rsp_valid = 0 for that response. The RAM read still occurs. Loader traffic is unaffected.
- **Fault reporting**: exactly one fault response per faulting request. Faults never self-clear combinationally.

## Timing

- Throughput is one accepted request per cycle in total, across both ports.
- Latency: accept at edge N, response valid during cycle N+1, for both clean and faulting requests.
- Responses have no backpressure. Requesters must accept a response in its valid cycle.
- A new request may be accepted in the same cycle a response is presented.
- **Reset** (rst low, asynchronous):
  - rsp_owner = NONE and last_grant = LD.
  - All *_valid, mem_en, mem_we, exc_en and ld_rsp_err are 0. exc_code, exc_val and rdata are 0. if_rsp_instr = 0x00000013.
  - A request accepted in the cycle of reset assertion produces no response.
- A loader write followed by a fetch of the same index in the next cycle returns the new data. Program order is preserved by the single port.

## Structure

- A shared package holds:
  - NOP_INSTR = 32'h00000013
  - EXC_INSTR_MISALIGNED = 4'd0
  - EXC_INSTR_ACCESS = 4'd1
  - the owner encoding (NONE / IF / LD).
- One sub-module, imem_addr_chk: a combinational address check (addr → misaligned, out_of_range, idx), instantiated once per port.
- The RAM stays outside this block.

## Test plan

- **Back-to-back fetches**: PC 0x0, 0x4 and 0x8 on consecutive cycles → if_rsp_valid on three consecutive cycles with words 0, 1 and 2. mem_en is high on every accept cycle.
- **Out-of-range fetch**: PC 0x2000 (index 2048) → one response with exc_en = 1, code 1, val 0x2000, instr 0x13, and mem_en = 0.
- **Misaligned and wide addresses**:
  - PC 0x2002 → code 0, not code 1.
  - PC 0x1_0000_0000 → code 1; there is no wrap to index 0.
- **Conflict**: both ports valid for 4 cycles from reset → grants IF, LD, IF, LD. A loader write of 0xDEADBEEF to 0x10, followed by a fetch of 0x10, returns 0xDEADBEEF.
- **Flush**: fetch accepted, if_flush asserted the next cycle → no if_rsp_valid. A loader read issued alongside is still answered.
- **Reset mid-operation**: rst low one cycle after a fetch is accepted → no response. All outputs match their reset values while rst is low.
